// File: rtl/buf_audio_in_if.sv
// ---------------------------------------------------------------------------
// buf_audio_in_if
// Read-side bus of the I2S receive buffer.
//   adv_read_enable    consumer -> buffer  single-cycle pop of the head word
//   audio_channel_out  buffer -> consumer  head word replicated on every channel
//   sample_valid       buffer -> consumer  buffer holds at least one word
//   buffer_ready       buffer -> consumer  buffer can accept another word
//   buffer_full        buffer -> consumer  buffer full, or an overflow has occurred
// Modports: slave = the buffer, master = the consumer.
// ---------------------------------------------------------------------------
interface buf_audio_in_if #(
    parameter int NUM_AUDIO_CHANNELS = 8,
    parameter int AUDIO_WIDTH        = 24
);
    logic                   adv_read_enable;
    logic [AUDIO_WIDTH-1:0] audio_channel_out [NUM_AUDIO_CHANNELS];
    logic                   sample_valid;
    logic                   buffer_ready;
    logic                   buffer_full;

    modport slave (
        input  adv_read_enable,
        output audio_channel_out,
        output sample_valid,
        output buffer_ready,
        output buffer_full
    );

    modport master (
        output adv_read_enable,
        input  audio_channel_out,
        input  sample_valid,
        input  buffer_ready,
        input  buffer_full
    );
endinterface

// File: rtl/buf_audio_in.sv
// ---------------------------------------------------------------------------
// buf_audio_in
// I2S receiver feeding a small FIFO. Serial words are captured in the sys_clk
// domain from synchronized copies of the I2S pins, MSB-aligned to AUDIO_WIDTH
// and queued. The head word is presented on every output channel.
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst    synchronous active-high reset
//   i2s_bclk   I2S bit clock (asynchronous, <= sys_clk/4)
//   i2s_lrclk  I2S word select (0 = left, 1 = right)
//   i2s_data   I2S serial data, MSB first
//   bus        buf_audio_in_if.slave read-side bus
//
// Build option: define BUF_AUDIO_IN_OVERWRITE_EN to make a push into a full
// FIFO overwrite the oldest entry instead of dropping the new word.
// ---------------------------------------------------------------------------
module buf_audio_in #(
    parameter int I2S_WIDTH          = 24,
    parameter int NUM_AUDIO_CHANNELS = 8,
    parameter int AUDIO_WIDTH        = 24,
    parameter int BUFFER_DEPTH       = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            i2s_bclk,
    input  logic            i2s_lrclk,
    input  logic            i2s_data,
    buf_audio_in_if.slave   bus
);
    localparam int CNT_W   = $clog2(I2S_WIDTH + 1);
    localparam int PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    typedef enum logic {
        ST_UNARMED,
        ST_ARMED
    } rx_state_t;

    // Receiver state
    logic [1:0]             r_bclk_sync, r_lrclk_sync, r_data_sync;
    logic                   r_prev_bclk, r_prev_lrclk;
    logic [I2S_WIDTH-1:0]   r_shift_reg;
    logic [CNT_W-1:0]       r_bit_counter;
    rx_state_t              r_rx_state, w_rx_state_next;

    // FIFO state
    logic [AUDIO_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_overflow;
    logic [AUDIO_WIDTH-1:0] r_audio_out;
    logic                   r_sample_valid;

    logic                   w_bclk_fall, w_lrclk_change;
    logic [I2S_WIDTH-1:0]   w_shift_next;
    logic [CNT_W-1:0]       w_bit_count_next;
    logic [AUDIO_WIDTH-1:0] w_word;
    logic                   w_push, w_pop, w_full, w_write;
    logic [PTR_W-1:0]       w_wr_ptr_next, w_rd_ptr_next;
    logic [COUNT_W-1:0]     w_count_next;
    logic                   w_overflow_next;
    logic [AUDIO_WIDTH-1:0] w_head_next;

    assign w_bclk_fall    = r_prev_bclk & ~r_bclk_sync[1];
    assign w_lrclk_change = r_prev_lrclk ^ r_lrclk_sync[1];

    // A bit arriving in the same cycle as the word-select change belongs to
    // the word that is ending, so the completeness check uses the next values.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_shift_next     = r_shift_reg;
        w_bit_count_next = r_bit_counter;
        if (w_bclk_fall) begin
            w_shift_next = {r_shift_reg[I2S_WIDTH-2:0], r_data_sync[1]};
            if (r_bit_counter != CNT_W'(I2S_WIDTH))
                w_bit_count_next = r_bit_counter + CNT_W'(1);
        end
    end

    generate
        if (I2S_WIDTH >= AUDIO_WIDTH) begin : g_truncate
            assign w_word = w_shift_next[I2S_WIDTH-1 -: AUDIO_WIDTH];
        end else begin : g_pad
            assign w_word = {w_shift_next, {(AUDIO_WIDTH-I2S_WIDTH){1'b0}}};
        end
    endgenerate

    // The first word-select change after reset only arms the receiver, so the
    // word in flight at reset release never reaches the FIFO.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_push          = 1'b0;
        if (w_lrclk_change) begin
            if (r_rx_state == ST_UNARMED)
                w_rx_state_next = ST_ARMED;
            else if (w_bit_count_next == CNT_W'(I2S_WIDTH))
                w_push = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_bclk_sync   <= '0;
            r_lrclk_sync  <= '0;
            r_data_sync   <= '0;
            r_prev_bclk   <= 1'b0;
            r_prev_lrclk  <= 1'b0;
            r_shift_reg   <= '0;
            r_bit_counter <= '0;
            r_rx_state    <= ST_UNARMED;
        end else begin
            r_bclk_sync   <= {r_bclk_sync[0],  i2s_bclk};
            r_lrclk_sync  <= {r_lrclk_sync[0], i2s_lrclk};
            r_data_sync   <= {r_data_sync[0],  i2s_data};
            r_prev_bclk   <= r_bclk_sync[1];
            r_prev_lrclk  <= r_lrclk_sync[1];
            r_shift_reg   <= w_shift_next;
            r_bit_counter <= w_lrclk_change ? '0 : w_bit_count_next;
            r_rx_state    <= w_rx_state_next;
        end
    end

    // FIFO next-state. Pointers are PTR_W bits wide, so they wrap on their own.
    assign w_pop  = bus.adv_read_enable && (r_count != '0);
    assign w_full = (r_count == COUNT_W'(BUFFER_DEPTH));

    always_comb begin
        w_write         = 1'b0;
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        if (w_pop)
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        if (w_push) begin
            if (!w_full || w_pop) begin
                w_write       = 1'b1;
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
                if (!w_pop)
                    w_count_next = r_count + COUNT_W'(1);
            end else begin
                w_overflow_next = 1'b1;
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
                // Full: the new word takes the oldest slot and the head moves on.
                w_write       = 1'b1;
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
`endif
            end
        end else if (w_pop) begin
            w_count_next = r_count - COUNT_W'(1);
        end

        // Outputs are registered from the next state; a word written this cycle
        // into the new head slot is forwarded since r_mem is not yet updated.
        if (w_count_next == '0)
            w_head_next = '0;
        else if (w_write && (w_rd_ptr_next == r_wr_ptr))
            w_head_next = w_word;
        else
            w_head_next = r_mem[w_rd_ptr_next];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_audio_out    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_overflow     <= w_overflow_next;
            r_audio_out    <= w_head_next;
            r_sample_valid <= (w_count_next != '0);
        end
    end

    // NOTE: storage is not reset; count and pointers define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && w_write)
            r_mem[r_wr_ptr] <= w_word;
    end

    generate
        for (genvar g = 0; g < NUM_AUDIO_CHANNELS; g++) begin : g_channel
            assign bus.audio_channel_out[g] = r_audio_out;
        end
    endgenerate

    assign bus.sample_valid = r_sample_valid;
    assign bus.buffer_ready = (r_count < COUNT_W'(BUFFER_DEPTH));
    assign bus.buffer_full  = w_full || r_overflow;

endmodule

// File: tb/tb_buf_audio_in.sv
// ---------------------------------------------------------------------------
// tb_buf_audio_in
// Bench for buf_audio_in: sys_clk 100 MHz, I2S bclk 25 MHz with data changed
// on the bclk rising edge. Words expected in the FIFO are queued in a model
// when their closing lrclk edge is driven and compared when read out.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buf_audio_in;
    localparam int NCH   = 8;
    localparam int AW    = 24;
    localparam int IW    = 24;
    localparam int DEPTH = 4;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic i2s_bclk, i2s_lrclk, i2s_data;

    buf_audio_in_if #(.NUM_AUDIO_CHANNELS(NCH), .AUDIO_WIDTH(AW)) bus();

    buf_audio_in #(
        .I2S_WIDTH(IW), .NUM_AUDIO_CHANNELS(NCH),
        .AUDIO_WIDTH(AW), .BUFFER_DEPTH(DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_data  (i2s_data),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard / reference model
    logic [AW-1:0] exp_q[$];
    bit            m_overflow;
    bit            m_armed;
    bit            m_pending_valid;
    logic [AW-1:0] m_pending_word;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_push(input logic [AW-1:0] w);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
        end else begin
            m_overflow = 1'b1;
`ifdef BUF_AUDIO_IN_OVERWRITE_EN
            void'(exp_q.pop_front());
            exp_q.push_back(w);
`endif
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_overflow      = 1'b0;
        m_armed         = 1'b0;
        m_pending_valid = 1'b0;
    endtask

    // All I2S activity is kept on a 10 ns grid, 2 ns after a sys_clk rising edge.
    task automatic send_bits(input logic [IW-1:0] w);
        for (int i = IW - 1; i >= 0; i--) begin
            i2s_data = w[i];
            i2s_bclk = 1'b1;
            #20;
            i2s_bclk = 1'b0;
            #20;
        end
        m_pending_word  = w[IW-1 -: AW];
        m_pending_valid = 1'b1;
    endtask

    task automatic toggle_lr();
        i2s_lrclk = ~i2s_lrclk;
        if (!m_armed)
            m_armed = 1'b1;
        else if (m_pending_valid)
            model_push(m_pending_word);
        m_pending_valid = 1'b0;
    endtask

    task automatic reset_dut();
        i2s_lrclk = 1'b0;
        i2s_bclk  = 1'b0;
        i2s_data  = 1'b0;
        bus.adv_read_enable = 1'b0;
        sys_rst = 1'b1;
        #40;
        sys_rst = 1'b0;
        #20;
        model_clear();
    endtask

    task automatic pop();
        bus.adv_read_enable = 1'b1;
        #10;
        bus.adv_read_enable = 1'b0;
        if (exp_q.size() > 0)
            void'(exp_q.pop_front());
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] exp_head;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_ch%0d", tag, i), 32'(bus.audio_channel_out[i]), 32'(exp_head));
        check({tag, "_valid"}, 32'(bus.sample_valid), 32'(exp_q.size() > 0));
        check({tag, "_full"},  32'(bus.buffer_full),  32'((exp_q.size() == DEPTH) || m_overflow));
        check({tag, "_ready"}, 32'(bus.buffer_ready), 32'(exp_q.size() < DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        sys_rst   = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_data  = 1'b0;
        bus.adv_read_enable = 1'b0;
        #7;
        reset_dut();
        #100;
        check_outputs("reset_idle");

        // Arm, then a left word with push-latency check, then a pop.
        toggle_lr(); #40;
        toggle_lr(); #40;
        send_bits(24'h123456);
        toggle_lr();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #10;
            if (bus.sample_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("push_latency", 32'(seen), 32'd1);
        #10;
        check_outputs("left_word");
        pop();
        check_outputs("left_popped");

        // Right word in the phase that was just opened.
        send_bits(24'hABCDEF);
        toggle_lr(); #60;
        check_outputs("right_word");
        pop();
        check_outputs("right_popped");

        // Six words without reads: overflow and sticky full.
        for (int k = 0; k < 6; k++) begin
            send_bits(24'h100000 + 24'(k));
            toggle_lr();
        end
        #60;
        check_outputs("six_words");
        pop();
        check_outputs("six_pop1");
        for (int k = 0; k < 3; k++) begin
            pop();
            check_outputs($sformatf("drain%0d", k));
        end
        pop();
        check_outputs("pop_empty");

        // Reset released in the middle of a left word.
        reset_dut();
        fork
            send_bits(24'h5A5A5A);
            begin
                #400;
                sys_rst = 1'b1;
                #30;
                sys_rst = 1'b0;
            end
        join
        model_clear();
        toggle_lr(); #60;
        check_outputs("mid_reset_partial");
        send_bits(24'hAA55AA);
        toggle_lr(); #60;
        check_outputs("mid_reset_next");
        pop();
        check_outputs("mid_reset_popped");

        // Patterns with a reset before each.
        for (int k = 0; k < 4; k++) begin
            reset_dut();
            toggle_lr(); #40;
            toggle_lr(); #40;
            send_bits(24'hAA55AA + 24'(k));
            toggle_lr(); #60;
            check_outputs($sformatf("pattern%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
